// File: rtl/mul_pkg.sv
// Shared constants and types for the iterative shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : mul_pkg

// File: rtl/mul_pipeline_32bit.sv
// Iterative unsigned multiplier: one multiplier bit per cycle, fixed WIDTH-cycle
// latency, low WIDTH product bits returned with a one-cycle ack pulse.
module mul_pipeline_32bit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             ack,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_ack_nxt;
    logic [WIDTH-1:0]   w_out_nxt;
    logic [WIDTH-1:0]   w_sum;
    logic               w_last;

    // Partial-product add for the current multiplier bit; wraps mod 2^WIDTH.
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            ack      <= 1'b0;
            out      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_count  <= w_count_nxt;
            ack      <= w_ack_nxt;
            out      <= w_out_nxt;
        end
    end

    // Next-state and datapath update; out holds except on the completion edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_count_nxt  = r_count;
        w_ack_nxt    = 1'b0;
        w_out_nxt    = out;

        case (r_state)
            IDLE: begin
                if (req) begin
                    w_mcand_nxt  = a;
                    w_mplier_nxt = b;
                    w_acc_nxt    = '0;
                    w_count_nxt  = '0;
                    w_state_nxt  = BUSY;
                end
            end
            BUSY: begin
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_count_nxt  = r_count + CNT_W'(1);
                if (w_last) begin
                    w_out_nxt   = w_sum;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : mul_pipeline_32bit

// File: tb/tb_mul_pipeline_32bit.sv
// Directed bench for mul_pipeline_32bit: latency, products, truncation, busy and reset handling.
module tb_mul_pipeline_32bit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        ack;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;

    int          checks;
    int          failures;
    logic [31:0] prev;

    mul_pipeline_32bit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .ack (ack),
        .a   (a),
        .b   (b),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full request: ack low on request edge and during BUSY, out holding prior
    // result, then ack exactly on edge E0+32 with the expected product.
    task automatic run(input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] exp, input string tag);
        logic early;
        logic hold;
        @(negedge clk);
        a   = op_a;
        b   = op_b;
        req = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ack_on_req_edge"}, 32'(ack), 32'd0);
        @(negedge clk);
        req = 1'b0;
        a   = 'x;
        b   = 'x;
        early = 1'b0;
        hold  = 1'b1;
        for (int i = 1; i < 32; i++) begin
            if (i > 1) @(negedge clk);
            @(posedge clk);
            #1;
            if (ack !== 1'b0) early = 1'b1;
            if (out !== prev) hold = 1'b0;
        end
        chk({tag, "_ack_during_busy"}, 32'(early), 32'd0);
        chk({tag, "_out_hold"}, 32'(hold), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_out"}, out, exp);
        @(posedge clk);
        #1;
        chk({tag, "_ack_drop"}, 32'(ack), 32'd0);
        prev = exp;
    endtask

    initial begin
        logic [31:0] seq_a [11];
        logic [31:0] seq_b [11];
        logic [31:0] seq_p [11];
        logic        extra;

        checks   = 0;
        failures = 0;
        prev     = 32'd0;
        rst      = 1'b1;
        req      = 1'b0;
        a        = 32'd0;
        b        = 32'd0;

        // Reset
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_out", out, 32'd0);
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ack !== 1'b0) extra = 1'b1;
        end
        chk("idle_no_ack", 32'(extra), 32'd0);

        // Basic products
        run(32'd3,   32'd5,  32'd15,   "m3x5");
        run(32'd15,  32'd4,  32'd60,   "m15x4");
        run(32'd7,   32'd3,  32'd21,   "m7x3");
        run(32'd127, 32'd31, 32'd3937, "m127x31");
        run(32'd150, 32'd40, 32'd6000, "m150x40");

        // Zero operand keeps fixed latency
        run(32'd15, 32'd0, 32'd0, "m15x0");

        // Large and boundary values
        run(32'd1254424,     32'd124,   32'd155548576,  "m_large");
        run(32'd347911,      32'd12345, 32'd4294961295, "m_maxfit");
        run(32'hFFFF_FFFF,   32'd2,     32'hFFFF_FFFE,  "m_trunc");

        // Eleven back-to-back requests
        seq_a[0]  = 32'd2;           seq_b[0]  = 32'd3;           seq_p[0]  = 32'd6;
        seq_a[1]  = 32'd10;          seq_b[1]  = 32'd10;          seq_p[1]  = 32'd100;
        seq_a[2]  = 32'd255;         seq_b[2]  = 32'd255;         seq_p[2]  = 32'd65025;
        seq_a[3]  = 32'd1000;        seq_b[3]  = 32'd1000;        seq_p[3]  = 32'd1000000;
        seq_a[4]  = 32'd65535;       seq_b[4]  = 32'd65537;       seq_p[4]  = 32'hFFFF_FFFF;
        seq_a[5]  = 32'd65536;       seq_b[5]  = 32'd65536;       seq_p[5]  = 32'd0;
        seq_a[6]  = 32'd12;          seq_b[6]  = 32'd12;          seq_p[6]  = 32'd144;
        seq_a[7]  = 32'd1;           seq_b[7]  = 32'hDEAD_BEEF;   seq_p[7]  = 32'hDEAD_BEEF;
        seq_a[8]  = 32'h8000_0000;   seq_b[8]  = 32'd3;           seq_p[8]  = 32'h8000_0000;
        seq_a[9]  = 32'd9;           seq_b[9]  = 32'd9;           seq_p[9]  = 32'd81;
        seq_a[10] = 32'd123;         seq_b[10] = 32'd456;         seq_p[10] = 32'd56088;
        for (int k = 0; k < 11; k++) begin
            run(seq_a[k], seq_b[k], seq_p[k], $sformatf("seq%0d", k));
        end

        // req during BUSY and on the ack edge are both ignored
        @(negedge clk);
        a   = 32'd6;
        b   = 32'd7;
        req = 1'b1;
        @(posedge clk);
        #1;
        extra = 1'b0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            req = (i == 10);
            a   = 32'd9;
            b   = 32'd9;
            @(posedge clk);
            #1;
            if (ack !== 1'b0) extra = 1'b1;
        end
        chk("busy_ack_early", 32'(extra), 32'd0);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_ack", 32'(ack), 32'd1);
        chk("busy_out", out, 32'd42);
        @(negedge clk);
        req   = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack !== 1'b0) extra = 1'b1;
        end
        chk("busy_no_second_ack", 32'(extra), 32'd0);
        chk("busy_out_held", out, 32'd42);
        prev = 32'd42;

        // Reset mid-operation aborts with no ack
        @(negedge clk);
        a   = 32'd100;
        b   = 32'd3;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack !== 1'b0) extra = 1'b1;
        end
        chk("midrst_no_ack", 32'(extra), 32'd0);
        chk("midrst_out", out, 32'd0);
        prev = 32'd0;
        run(32'd13, 32'd17, 32'd221, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_pipeline_32bit

// File: doc/mul_pipeline_32bit.md
Name: mul_pipeline_32bit

Overview:
- Multi-cycle unsigned integer multiplier for the integer execution path.
- Accepts a one-cycle request carrying two WIDTH-bit operands.
- Computes the product iteratively (shift-and-add, one multiplier bit per cycle).
- Returns the low WIDTH bits of the product with a one-cycle ack pulse; the core stalls on ack.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  start request, sampled on clk rising edge, one-cycle pulse
- ack  output  1  result-valid pulse, exactly one cycle per accepted request
- a  input  WIDTH  multiplicand, sampled with req
- b  input  WIDTH  multiplier, sampled with req
- out  output  WIDTH  product low WIDTH bits, valid while ack=1 and held until next result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ack=0; out=0; internal accumulator, shifted operands and counter cleared.
  - Reset mid-operation aborts the multiply with no ack.
- States:
  - IDLE: waits for req.
  - BUSY: iterating.
- IDLE with req=1 at edge E0:
  - Latch a into mcand (WIDTH bits, shifts left and truncates) and b into mplier.
  - acc=0, count=0, state=BUSY.
  - ack stays 0 after E0.
- BUSY, each edge:
  - If mplier[0], acc <= acc + mcand, mod 2^WIDTH.
  - mcand <<= 1; mplier >>= 1; count++.
- Latency:
  - On the edge where count reaches WIDTH (edge E0+32 for WIDTH=32): out <= final acc (including that cycle's add), ack <= 1, state <= IDLE.
  - So ack is high in the 32nd cycle after the request edge.
  - Latency is fixed at WIDTH cycles and independent of operand values; zero operands do not terminate early.
- ack is registered and deasserts on the next edge (one-cycle pulse). It is never high during BUSY or on the request edge.
- out:
  - Updates only on the completion edge.
  - Otherwise holds its last value, including during the next operation's BUSY phase.
- Arithmetic:
  - Unsigned.
  - Result is (a*b) mod 2^WIDTH; upper product bits are discarded with no overflow flag.
- req while BUSY is ignored (not queued).
- req on the same edge ack is asserted: the FSM has just returned to IDLE, so that req is ignored. Requesters must wait for ack and issue the next req on a later edge.
- req held high in IDLE for multiple cycles: each IDLE-sampled high starts one operation, i.e. a new operation starts the cycle after ack.
- X on a/b is irrelevant when req=0 in IDLE.

Decomposition:
- Shared package mul_pkg:
  - WIDTH default constant.
  - State enum typedef (IDLE, BUSY).
  - Counter width constant $clog2(WIDTH)+1.
- Single flat module; no sub-module needed.
- The datapath (adder plus two shifters) stays inline.

Test Plan:
- Reset: rst=1 for one cycle, then release → ack=0 and out=0; ack remains 0 with no req.
- Basic products, each req pulsed one cycle with ack checked low immediately after the request edge. Each → ack exactly once, 32 cycles after the request, and ack low on the following edge:
  - 3*5 → 15
  - 15*4 → 60
  - 7*3 → 21
  - 127*31 → 3937
  - 150*40 → 6000
- Zero operand: 15*0 → out=0, ack still at the fixed 32-cycle latency.
- Large and boundary values:
  - 1254424*124 → 155548576
  - 347911*12345 → 4294961295 (max-range fit)
  - 0xFFFFFFFF*2 → 0xFFFFFFFE (truncation)
- Back-to-back and busy handling:
  - 11 sequential requests, each issued one cycle after the prior ack → all results correct, and out holds the previous result until the next completion.
  - req during BUSY → ignored, with only one ack.
- Reset mid-operation: assert rst at cycle 10 of BUSY → ack never pulses, out=0; a new request after reset completes correctly.
